// File: rtl/fwd_hazard_unit.sv
// Purpose: operand forwarding selects and issue stall from an in-flight producer scoreboard.
// Latency: sel and stall are combinational from the scoreboard and current issue inputs.
// Backpressure: stall holds the issuing instruction and shifts a bubble into the pipe.
module fwd_hazard_unit #(
  parameter int REG_LOG = 5,
  parameter int NSTAGES = 3,
  parameter int NREAD   = 2,
  localparam int SELW   = $clog2(NSTAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [NREAD*REG_LOG-1:0] issue_rs,
  input  logic [REG_LOG-1:0]       issue_rd,
  input  logic                     issue_we,
  input  logic [2:0]               issue_lat,
  input  logic                     flush,
  output logic [NREAD*SELW-1:0]    sel,
  output logic                     stall,
  output logic [15:0]              stall_cnt
);

  // Scoreboard entry k describes the producer k+1 cycles past issue; cnt is cycles until its result exists.
  logic               ent_vld [NSTAGES];
  logic [REG_LOG-1:0] ent_rd  [NSTAGES];
  logic [2:0]         ent_cnt [NSTAGES];

  logic [NREAD-1:0]   hazard;
  logic [2:0]         eff_lat;
  logic               load_ok;

  // Clamp the requested latency into 1..NSTAGES so a result is always forwardable before retiring.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == 3'd0) begin
      eff_lat = 3'd1;
    end else if (int'(issue_lat) > NSTAGES) begin
      eff_lat = 3'(NSTAGES);
    end
  end

  // Per-operand lookup: scanning oldest to youngest lets the youngest matching producer win,
  // so an older ready copy never masks a younger one that is still computing.
  for (genvar i = 0; i < NREAD; i++) begin : g_op
    logic [REG_LOG-1:0] rs;
    logic               hit;
    logic               hit_rdy;
    logic [SELW-1:0]    hit_sel;
    logic               active;

    assign rs     = issue_rs[i*REG_LOG +: REG_LOG];
    assign active = issue_valid && (rs != '0) && hit;

    // Find the youngest in-flight producer of rs and whether its result is ready.
    always_comb begin
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_sel = '0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (ent_vld[k] && (ent_rd[k] == rs)) begin
          hit     = 1'b1;
          hit_rdy = (ent_cnt[k] == 3'd0);
          hit_sel = SELW'(k + 1);
        end
      end
    end

    assign hazard[i]             = active && !hit_rdy;
    assign sel[i*SELW +: SELW]   = (active && hit_rdy) ? hit_sel : '0;
  end

  // A flushed issue never stalls; the stall depends only on state and inputs, never on itself.
  assign stall   = issue_valid && !flush && (|hazard);
  assign load_ok = issue_valid && !stall && !flush;

  // Advance the scoreboard; flush kills every younger entry, keeping only the oldest survivor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        ent_vld[k] <= 1'b0;
        ent_rd[k]  <= '0;
        ent_cnt[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        ent_vld[k] <= ent_vld[k-1] && !(flush && (k <= NSTAGES - 2));
        ent_rd[k]  <= ent_rd[k-1];
        ent_cnt[k] <= (ent_cnt[k-1] == 3'd0) ? 3'd0 : ent_cnt[k-1] - 3'd1;
      end
      // x0 is never a real destination, so it does not occupy the scoreboard.
      ent_vld[0] <= load_ok && issue_we && (issue_rd != '0);
      ent_rd[0]  <= issue_rd;
      ent_cnt[0] <= eff_lat - 3'd1;
    end
  end

  // Count stalled cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;

  // Main instance: NSTAGES=3, NREAD=2
  logic        issue_valid;
  logic [9:0]  issue_rs;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic [2:0]  issue_lat;
  logic        flush;
  logic [3:0]  sel;
  logic        stall;
  logic [15:0] stall_cnt;

  // Deep instance used for the stall counter saturation run: NSTAGES=7, NREAD=1
  logic        b_issue_valid;
  logic [4:0]  b_issue_rs;
  logic [4:0]  b_issue_rd;
  logic        b_issue_we;
  logic [2:0]  b_issue_lat;
  logic        b_flush;
  logic [2:0]  b_sel;
  logic        b_stall;
  logic [15:0] b_stall_cnt;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_LOG(5), .NSTAGES(3), .NREAD(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rd    (issue_rd),
    .issue_we    (issue_we),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .sel         (sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  fwd_hazard_unit #(.REG_LOG(5), .NSTAGES(7), .NREAD(1)) dut_deep (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (b_issue_valid),
    .issue_rs    (b_issue_rs),
    .issue_rd    (b_issue_rd),
    .issue_we    (b_issue_we),
    .issue_lat   (b_issue_lat),
    .flush       (b_flush),
    .sel         (b_sel),
    .stall       (b_stall),
    .stall_cnt   (b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic we, input logic [2:0] lat,
                       input logic fl);
    issue_valid = v;
    issue_rs    = {rs1, rs0};
    issue_rd    = rd;
    issue_we    = we;
    issue_lat   = lat;
    flush       = fl;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 3'd3, 1'b0);
    b_issue_valid = 1'b0; b_issue_rs = '0; b_issue_rd = '0;
    b_issue_we = 1'b0; b_issue_lat = 3'd1; b_flush = 1'b0;
    #2;
    total++; if (sel !== 4'd0) begin bad++; $display("FAIL reset_sel got=%0h exp=0", sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    repeat (2) step();
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_alu_back_to_back();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 3'd1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_prod_stall got=%0b exp=0", stall); end
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (sel !== 4'b0001 || stall !== 1'b0)
      begin bad++; $display("FAIL alu_fwd1 got sel=%0h stall=%0b exp sel=1 stall=0", sel, stall); end
    step();
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (sel !== 4'b1000 || stall !== 1'b0)
      begin bad++; $display("FAIL alu_fwd2 got sel=%0h stall=%0b exp sel=8 stall=0", sel, stall); end
    step();
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'd2, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (stall !== 1'b1 || sel !== 4'd0)
      begin bad++; $display("FAIL load_use_stall got stall=%0b sel=%0h exp stall=1 sel=0", stall, sel); end
    step();
    #1;
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    total++; if (sel !== 4'b0010 || stall !== 1'b0)
      begin bad++; $display("FAIL load_use_fwd got sel=%0h stall=%0b exp sel=2 stall=0", sel, stall); end
    step();
    drain();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd1, 1'b0);
    step();
    step();
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 3'd3, 1'b0);
    #1;
    total++; if (sel !== 4'b0101 || stall !== 1'b0)
      begin bad++; $display("FAIL youngest_both got sel=%0h stall=%0b exp sel=5 stall=0", sel, stall); end
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'd3, 1'b0);
    #1;
    total++; if (sel !== 4'd0 || stall !== 1'b0)
      begin bad++; $display("FAIL x0_regs got sel=%0h stall=%0b exp sel=0 stall=0", sel, stall); end
    step();
    drain();
    // Older ready x3 must not override a younger x3 that is not ready yet.
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (stall !== 1'b1 || sel !== 4'd0)
      begin bad++; $display("FAIL youngest_not_ready got stall=%0b sel=%0h exp stall=1 sel=0", stall, sel); end
    step();
    total++; if (sel !== 4'b0010 || stall !== 1'b0)
      begin bad++; $display("FAIL youngest_ready got sel=%0h stall=%0b exp sel=2 stall=0", sel, stall); end
    step();
    drain();
  endtask

  task automatic test_lat_clamp();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 3'd0, 1'b0);
    step();
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (sel !== 4'b0001 || stall !== 1'b0)
      begin bad++; $display("FAIL lat0_fwd got sel=%0h stall=%0b exp sel=1 stall=0", sel, stall); end
    step();
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 3'd7, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd6, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lat7_stall1 got=%0b exp=1", stall); end
    step();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lat7_stall2 got=%0b exp=1", stall); end
    step();
    total++; if (sel !== 4'b1100 || stall !== 1'b0)
      begin bad++; $display("FAIL lat7_fwd got sel=%0h stall=%0b exp sel=c stall=0", sel, stall); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL lat7_cnt got=%0d exp=4", stall_cnt); end
    step();
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 3'd3, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    step();
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    #1;
    total++; if (sel !== 4'd0 || stall !== 1'b0)
      begin bad++; $display("FAIL flush_killed got sel=%0h stall=%0b exp sel=0 stall=0", sel, stall); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_cnt got=%0d exp=4", stall_cnt); end
    step();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'd3, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0);
    step();
    total++; if (stall !== 1'b1 || stall_cnt !== 16'd5)
      begin bad++; $display("FAIL pre_reset got stall=%0b cnt=%0d exp stall=1 cnt=5", stall, stall_cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || sel !== 4'd0 || stall_cnt !== 16'd0)
      begin bad++; $display("FAIL mid_reset got stall=%0b sel=%0h cnt=%0d exp 0/0/0", stall, sel, stall_cnt); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || sel !== 4'd0)
      begin bad++; $display("FAIL post_reset got stall=%0b sel=%0h exp stall=0 sel=0", stall, sel); end
    step();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL post_reset_cnt got=%0d exp=0", stall_cnt); end
    drain();
  endtask

  task automatic test_saturation();
    // Each group: a latency-7 producer of x1, then six stalled cycles waiting on it.
    for (int g = 0; g < 10923; g++) begin
      if (g == 10922) begin
        total++; if (b_stall_cnt !== 16'd65532)
          begin bad++; $display("FAIL sat_pre got=%0d exp=65532", b_stall_cnt); end
      end
      b_issue_valid = 1'b1; b_issue_rs = 5'd0; b_issue_rd = 5'd1;
      b_issue_we = 1'b1; b_issue_lat = 3'd7;
      step();
      b_issue_rs = 5'd1; b_issue_we = 1'b0;
      repeat (6) step();
    end
    total++; if (b_stall_cnt !== 16'hFFFF)
      begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", b_stall_cnt); end
    total++; if (b_sel !== 3'd7 || b_stall !== 1'b0)
      begin bad++; $display("FAIL sat_fwd7 got sel=%0d stall=%0b exp sel=7 stall=0", b_sel, b_stall); end
    rst_n = 1'b0;
    #1;
    total++; if (b_stall_cnt !== 16'd0)
      begin bad++; $display("FAIL sat_reset got=%0d exp=0", b_stall_cnt); end
    b_issue_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_youngest();
    test_lat_clamp();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
